// File: rtl/uart_echo_buffer_pkg.sv
// Shared types and constants for the UART echo buffer: launch FSM states,
// the CR/LF characters used by the optional UART_ECHO_CRLF_EN build, and a level-width helper.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        INJECT
    } echo_state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Single-clock FIFO with registered level/empty/full; Depth must be a power of two.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo
    import uart_echo_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [DataWidth-1:0]          i_data,
    output logic [DataWidth-1:0]          o_head,
    output logic [level_width(Depth)-1:0] o_level,
    output logic                          o_empty,
    output logic                          o_full
);

    localparam int AddrWidth  = $clog2(Depth);
    localparam int LevelWidth = level_width(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  do_push, do_pop;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_pop   = i_pop && !empty_q;
        do_push  = i_push && (!full_q || do_pop);

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        empty_d = (level_d == '0);
        full_d  = (level_d == LevelWidth'(Depth));
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers already mark it invalid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_level = level_q;
    assign o_empty = empty_q;
    assign o_full  = full_q;

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered echo core between uart_rx and uart_tx: FIFO, launch FSM, overflow flag, hold.
// Define UART_ECHO_CRLF_EN (DataWidth == 8 only) to send LF after every completed CR.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    parameter int BusyWait  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_valid,
    input  logic [DataWidth-1:0]          i_rx_byte,
    input  logic                          i_tx_busy,
    input  logic                          i_hold,
    input  logic                          i_clr_overflow,
    output logic                          o_tx_enable,
    output logic [DataWidth-1:0]          o_tx_data,
    output logic [level_width(Depth)-1:0] o_level,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_overflow
);

    localparam int CntWidth = $clog2(BusyWait + 1);

    echo_state_e          state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [DataWidth-1:0] tx_data_q, tx_data_d;
    logic                 tx_enable_q, tx_enable_d;
    logic                 overflow_q, overflow_d;
    logic [DataWidth-1:0] fifo_head;
    logic                 fifo_pop, fifo_empty, fifo_full;

    sync_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_rx_valid),
        .i_pop   (fifo_pop),
        .i_data  (i_rx_byte),
        .o_head  (fifo_head),
        .o_level (o_level),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !i_hold) begin
                    fifo_pop    = 1'b1;
                    tx_data_d   = fifo_head;
                    tx_enable_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_BUSY;
                end
            end
            // A transmitter that never answers is treated as done; the byte is not retried.
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CntWidth'(BusyWait - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
                    state_d = (tx_data_q == DataWidth'(CHAR_CR)) ? INJECT : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            INJECT: begin
                tx_data_d   = DataWidth'(CHAR_LF);
                tx_enable_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT_BUSY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (i_clr_overflow) overflow_d = 1'b0;
        if (i_rx_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_tx_enable = tx_enable_q;
    assign o_tx_data   = tx_data_q;
    assign o_empty     = fifo_empty;
    assign o_full      = fifo_full;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: queue-based reference model with a
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_uart_echo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int BW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_rx_valid = 1'b0;
    logic [DW-1:0] i_rx_byte = '0;
    logic          i_tx_busy = 1'b0;
    logic          i_hold = 1'b0;
    logic          i_clr_overflow = 1'b0;
    logic          o_tx_enable;
    logic [DW-1:0] o_tx_data;
    logic [LW-1:0] o_level;
    logic          o_empty, o_full, o_overflow;

    always #5 i_clk = ~i_clk;

    uart_echo_buffer #(
        .DataWidth (DW),
        .Depth     (DEPTH),
        .BusyWait  (BW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx_valid     (i_rx_valid),
        .i_rx_byte      (i_rx_byte),
        .i_tx_busy      (i_tx_busy),
        .i_hold         (i_hold),
        .i_clr_overflow (i_clr_overflow),
        .o_tx_enable    (o_tx_enable),
        .o_tx_data      (o_tx_data),
        .o_level        (o_level),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_overflow     (o_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a byte queue plus the cycle at which the launcher is next free.
    logic [7:0] q[$];
    int         idle_at   = 0;
    bit         inj_pend  = 1'b0;
    bit         model_ov  = 1'b0;
    bit         busy_mode = 1'b1;
    int         busy_len  = 1;
    int         busy_start = 0;
    int         busy_end   = 0;
    bit         nxt_en = 1'b0, cur_en = 1'b0;
    logic [7:0] nxt_data = '0, cur_data = '0;
    int         nxt_level = 0, cur_level = 0;
    bit         nxt_ov = 1'b0, cur_ov = 1'b0;
    bit         chk_en = 1'b0;
    int         last_cyc = 0;

    // Observed launches and peak level, for the directed literal checks.
    int         en_cyc[$];
    logic [7:0] en_data[$];
    int         max_level = 0;

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("tx_enable", o_tx_enable, cur_en);
            check("tx_data", o_tx_data, cur_data);
            check("level", o_level, cur_level);
            check("empty", o_empty, cur_level == 0);
            check("full", o_full, cur_level == DEPTH);
            check("overflow", o_overflow, cur_ov);
            if (o_tx_enable === 1'b1) begin
                en_cyc.push_back(cyc);
                en_data.push_back(o_tx_data);
            end
            if (int'(o_level) > max_level) max_level = int'(o_level);
        end
    end

    // Launch decided in cycle cyc: pulse appears next cycle, launcher free again after
    // the handshake (busy rises 1 cycle after the pulse) or after the BusyWait timeout.
    task automatic launch(input logic [7:0] d);
        nxt_en   = 1'b1;
        nxt_data = d;
        if (busy_mode) begin
            idle_at  = cyc + 3 + busy_len;
            inj_pend = CRLF && (d == 8'h0D);
        end else begin
            idle_at  = cyc + 1 + BW;
            inj_pend = 1'b0;
        end
    endtask

    task automatic step(input bit rxv, input logic [7:0] b, input bit hold, input bit clr);
        bit drop;
        @(posedge i_clk);
        #1;
        last_cyc  = cyc;
        cur_en    = nxt_en;
        cur_data  = nxt_data;
        cur_level = nxt_level;
        cur_ov    = nxt_ov;
        if (cur_en && busy_mode) begin
            busy_start = cyc + 1;
            busy_end   = cyc + 1 + busy_len;
        end
        i_tx_busy      = (cyc >= busy_start) && (cyc < busy_end);
        i_rx_valid     = rxv;
        i_rx_byte      = b;
        i_hold         = hold;
        i_clr_overflow = clr;

        nxt_en = 1'b0;
        if (cyc >= idle_at) begin
            if (inj_pend) launch(8'h0A);
            else if (q.size() > 0 && !hold) launch(q.pop_front());
        end
        drop = 1'b0;
        if (rxv) begin
            if (q.size() < DEPTH) q.push_back(b);
            else drop = 1'b1;
        end
        if (drop) model_ov = 1'b1;
        else if (clr) model_ov = 1'b0;
        nxt_level = q.size();
        nxt_ov    = model_ov;
    endtask

    task automatic idle(input int n, input bit hold);
        repeat (n) step(1'b0, 8'h00, hold, 1'b0);
    endtask

    task automatic clear_log();
        en_cyc.delete();
        en_data.delete();
        max_level = 0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_rx_valid = 1'b0; i_hold = 1'b0; i_clr_overflow = 1'b0; i_tx_busy = 1'b0;
        #1;
        check("rst_tx_enable", o_tx_enable, 1'b0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_level", o_level, 0);
        check("rst_empty", o_empty, 1'b1);
        check("rst_full", o_full, 1'b0);
        check("rst_overflow", o_overflow, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        q.delete();
        idle_at = 0; inj_pend = 1'b0; model_ov = 1'b0;
        busy_start = 0; busy_end = 0;
        nxt_en = 1'b0; nxt_data = '0; nxt_level = 0; nxt_ov = 1'b0;
        cur_en = 1'b0; cur_data = '0; cur_level = 0; cur_ov = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] exp_seq[$];
        do_reset();

        // Single byte: pulse two cycles after the strobe, exactly once.
        busy_mode = 1'b1; busy_len = 20; clear_log();
        step(1'b1, 8'h41, 1'b0, 1'b0);
        n = last_cyc;
        idle(30, 1'b0);
        check("single_count", en_cyc.size(), 1);
        if (en_cyc.size() > 0) begin
            check("single_latency", en_cyc[0], n + 2);
            check("single_data", en_data[0], 8'h41);
        end
        @(negedge i_clk);
        check("single_level_end", o_level, 0);

        // Burst while the transmitter is busy: first byte leaves, four queue up.
        busy_mode = 1'b1; busy_len = 8; clear_log();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        idle(80, 1'b0);
        check("burst_peak", max_level, 4);
        check("burst_count", en_data.size(), 5);
        for (int i = 0; i < 5 && i < en_data.size(); i++) check("burst_order", en_data[i], 8'(i + 1));
        check("burst_overflow", o_overflow, 1'b0);

        // Hold with overflow: 6 pushes into 4 entries, then clear racing a drop.
        clear_log();
        for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge i_clk);
        check("hold_full", o_full, 1'b1);
        check("hold_level", o_level, 4);
        check("hold_overflow", o_overflow, 1'b1);
        check("hold_no_launch", en_data.size(), 0);
        step(1'b1, 8'h16, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge i_clk);
        check("clr_vs_set", o_overflow, 1'b1);
        idle(60, 1'b0);
        check("hold_count", en_data.size(), 4);
        for (int i = 0; i < 4 && i < en_data.size(); i++) check("hold_order", en_data[i], 8'h10 + 8'(i));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge i_clk);
        check("clr_overflow", o_overflow, 1'b0);

        // Transmitter never answers: next launch after the BusyWait timeout.
        busy_mode = 1'b0; clear_log();
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        idle(30, 1'b0);
        check("timeout_count", en_cyc.size(), 2);
        if (en_cyc.size() == 2) check("timeout_spacing", en_cyc[1] - en_cyc[0], BW + 1);

        // Reset while waiting for busy to drop, with a byte still queued.
        busy_mode = 1'b1; busy_len = 10;
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0);
        idle(3, 1'b0);
        do_reset();
        idle(20, 1'b0);

        // CR handling: LF appended only when the feature is built in.
        busy_mode = 1'b1; busy_len = 2; clear_log();
        step(1'b1, 8'h0D, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        idle(40, 1'b0);
        exp_seq.delete();
        exp_seq.push_back(8'h0D);
        if (CRLF) exp_seq.push_back(8'h0A);
        exp_seq.push_back(8'h42);
        check("crlf_count", en_data.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < en_data.size(); i++) check("crlf_seq", en_data[i], exp_seq[i]);

        // Random traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            bit hold_r;
            busy_mode = seg[0];
            busy_len  = $urandom_range(1, 5);
            hold_r    = 1'b0;
            for (int k = 0; k < 250; k++) begin
                logic [7:0] b;
                if ($urandom_range(0, 99) < 5) hold_r = ~hold_r;
                b = ($urandom_range(0, 9) == 0) ? 8'h0D : 8'($urandom);
                step($urandom_range(0, 99) < 45, b, hold_r, $urandom_range(0, 99) < 5);
            end
            idle(80, 1'b0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
